// File: rtl/uart_rx.sv
// uart_rx: 8N1-style UART receiver with one sample per rising edge of baud_tick.
// It passes rx through a metastability synchronizer, then assembles
// DATA_BITS data bits, LSB first. It presents the last well-framed byte on
// data, together with a sticky valid flag.
// Optional feature: define UART_RX_FRAME_ERR_EN to add a sticky frame_err
// output. frame_err is set when a stop-bit sample is 0.
`timescale 1ns/1ps

module uart_rx #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 baud_tick,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic                 frame_err
`endif
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   tick_q, tick_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
`ifdef UART_RX_FRAME_ERR_EN
  logic                   frame_err_q, frame_err_d;
`endif

  logic rx_s;
  logic strobe;

  assign rx_s   = sync_q[SYNC_STAGES-1];
  assign strobe = baud_tick & ~tick_q;

  assign data  = data_q;
  assign valid = valid_q;
`ifdef UART_RX_FRAME_ERR_EN
  assign frame_err = frame_err_q;
`endif

  // Synchronizer shift and tick edge register; both simply follow their inputs
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], rx};
    tick_d = baud_tick;
  end

  // Frame FSM: every decision is taken only in strobe cycles
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
`ifdef UART_RX_FRAME_ERR_EN
    frame_err_d = frame_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (strobe && !rx_s) begin
          valid_d = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
          frame_err_d = 1'b0;
`endif
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (strobe) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_BITS - 1)) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (strobe) begin
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
`ifdef UART_RX_FRAME_ERR_EN
            frame_err_d = 1'b1;
`endif
          end
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous reset; the synchronizer resets to the idle-high line level
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q  <= '1;
      tick_q  <= 1'b0;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      frame_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      tick_q  <= tick_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
`ifdef UART_RX_FRAME_ERR_EN
      frame_err_q <= frame_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx. It uses a 50 MHz clock and a
// 505-cycle (10.1 us) bit period. The tick is placed 250 cycles into each bit.
`timescale 1ns/1ps

module tb_uart_rx;

  localparam int BIT_CYC  = 505;
  localparam int TICK_OFS = 250;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       baud_tick;
  logic [7:0] data;
  logic       valid;
`ifdef UART_RX_FRAME_ERR_EN
  logic       frame_err;
`endif

  int vectors;
  int miscompares;

  uart_rx #(
    .DATA_BITS  (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .baud_tick(baud_tick),
    .data     (data),
    .valid    (valid)
`ifdef UART_RX_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  // 50 MHz clock
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bit period: drive rx, then hold the tick high for hi_cycles, 250 cycles into the bit
  task automatic applyStimulus(input logic b, input int hi_cycles);
    rx = b;
    repeat (TICK_OFS) @(negedge clk);
    baud_tick = 1'b1;
    repeat (hi_cycles) @(negedge clk);
    baud_tick = 1'b0;
    repeat (BIT_CYC - TICK_OFS - hi_cycles) @(negedge clk);
  endtask

  // Whole frame: start bit, eight data bits LSB first, then the stop bit
  task automatic sendFrame(input logic [7:0] byte_v, input logic stop_v, input int hi_cycles);
    applyStimulus(1'b0, hi_cycles);
    for (int i = 0; i < 8; i++) applyStimulus(byte_v[i], hi_cycles);
    applyStimulus(stop_v, hi_cycles);
    rx = 1'b1;
  endtask

  // Synchronous reset pulse lasting a few cycles
  task automatic doReset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Directed sequence
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    rx          = 1'b1;
    baud_tick   = 1'b0;
    @(negedge clk);
    doReset();
    checkOutput("reset_data", 32'(data), 32'h00);
    checkOutput("reset_valid", 32'(valid), 32'h0);
`ifdef UART_RX_FRAME_ERR_EN
    checkOutput("reset_ferr", 32'(frame_err), 32'h0);
`endif

    // Good 0xA5 frame, followed by a 50 us hold
    sendFrame(8'hA5, 1'b1, 5);
    checkOutput("a5_data", 32'(data), 32'hA5);
    checkOutput("a5_valid", 32'(valid), 32'h1);
    repeat (2500) @(negedge clk);
    checkOutput("a5_hold_data", 32'(data), 32'hA5);
    checkOutput("a5_hold_valid", 32'(valid), 32'h1);

    // Framing error: the stop bit is driven low
    doReset();
    sendFrame(8'hA5, 1'b0, 5);
    checkOutput("ferr_data", 32'(data), 32'h00);
    checkOutput("ferr_valid", 32'(valid), 32'h0);
`ifdef UART_RX_FRAME_ERR_EN
    checkOutput("ferr_flag", 32'(frame_err), 32'h1);
`endif
    repeat (20) @(negedge clk);

    // Back-to-back 0x3C then 0xFF; valid must drop at the second start strobe
    sendFrame(8'h3C, 1'b1, 5);
    checkOutput("b2b_first_data", 32'(data), 32'h3C);
    checkOutput("b2b_first_valid", 32'(valid), 32'h1);
`ifdef UART_RX_FRAME_ERR_EN
    checkOutput("b2b_ferr_clr", 32'(frame_err), 32'h0);
`endif
    applyStimulus(1'b0, 5);
    checkOutput("b2b_start_valid", 32'(valid), 32'h0);
    checkOutput("b2b_start_data", 32'(data), 32'h3C);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 5);
    applyStimulus(1'b1, 5);
    checkOutput("b2b_second_data", 32'(data), 32'hFF);
    checkOutput("b2b_second_valid", 32'(valid), 32'h1);

    // Glitch low for 5 clk between ticks while idle; it must be ignored
    repeat (100) @(negedge clk);
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (TICK_OFS) @(negedge clk);
    baud_tick = 1'b1;
    repeat (5) @(negedge clk);
    baud_tick = 1'b0;
    repeat (200) @(negedge clk);
    checkOutput("glitch_valid", 32'(valid), 32'h1);
    checkOutput("glitch_data", 32'(data), 32'hFF);
    sendFrame(8'h00, 1'b1, 5);
    checkOutput("zero_data", 32'(data), 32'h00);
    checkOutput("zero_valid", 32'(valid), 32'h1);

    // Reset after 4 data bits of 0x81, then resend the whole frame
    applyStimulus(1'b0, 5);
    applyStimulus(1'b1, 5);
    applyStimulus(1'b0, 5);
    applyStimulus(1'b0, 5);
    applyStimulus(1'b0, 5);
    rx = 1'b1;
    doReset();
    checkOutput("midrst_data", 32'(data), 32'h00);
    checkOutput("midrst_valid", 32'(valid), 32'h0);
    repeat (100) @(negedge clk);
    sendFrame(8'h81, 1'b1, 5);
    checkOutput("resend_data", 32'(data), 32'h81);
    checkOutput("resend_valid", 32'(valid), 32'h1);

    // Long ticks: 20 cycles high per bit, frame 0x5A
    sendFrame(8'h5A, 1'b1, 20);
    checkOutput("longtick_data", 32'(data), 32'h5A);
    checkOutput("longtick_valid", 32'(valid), 32'h1);

    // No tick activity: everything holds
    rx = 1'b0;
    repeat (1000) @(negedge clk);
    checkOutput("notick_data", 32'(data), 32'h5A);
    checkOutput("notick_valid", 32'(valid), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
